// File: rtl/baud_generator.sv
// Baud-rate clock generator for the UART.
// Divides i_clk by a divisor chosen from a fixed ten-entry baud table and
// produces a baud clock plus three single-cycle strobes (rising-edge
// imminent, falling-edge imminent, mid-high stable sample point).
// All outputs are registered and reflect the phase counter value that is
// being loaded at the same edge. A load therefore shows o_clk=1 immediately,
// and every strobe lines up with the cycle in which C holds its trigger value.
module baud_generator #(
  parameter int FPGA_CLK = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_baud_select,
  input  logic       i_update_baud,
  output logic       o_clk,
  output logic       o_rising_edge,
  output logic       o_falling_edge,
  output logic       o_stable
);

  // 9600 baud gives the largest divisor, so it sets the counter width.
  localparam int DIV_MAX = FPGA_CLK / 9600;
  localparam int CW      = ($clog2(DIV_MAX) > 14) ? $clog2(DIV_MAX) : 14;

  localparam logic [CW-1:0] DIV_0 = CW'(FPGA_CLK / 9600);
  localparam logic [CW-1:0] DIV_1 = CW'(FPGA_CLK / 19200);
  localparam logic [CW-1:0] DIV_2 = CW'(FPGA_CLK / 38400);
  localparam logic [CW-1:0] DIV_3 = CW'(FPGA_CLK / 57600);
  localparam logic [CW-1:0] DIV_4 = CW'(FPGA_CLK / 115200);
  localparam logic [CW-1:0] DIV_5 = CW'(FPGA_CLK / 230400);
  localparam logic [CW-1:0] DIV_6 = CW'(FPGA_CLK / 460800);
  localparam logic [CW-1:0] DIV_7 = CW'(FPGA_CLK / 921600);
  localparam logic [CW-1:0] DIV_8 = CW'(FPGA_CLK / 1000000);
  localparam logic [CW-1:0] DIV_9 = CW'(FPGA_CLK / 1500000);

  // Table lookup; indices 10..15 fall back to 9600 baud.
  function automatic logic [CW-1:0] div_lookup(input logic [3:0] sel);
    logic [CW-1:0] d;
    case (sel)
      4'd0:    d = DIV_0;
      4'd1:    d = DIV_1;
      4'd2:    d = DIV_2;
      4'd3:    d = DIV_3;
      4'd4:    d = DIV_4;
      4'd5:    d = DIV_5;
      4'd6:    d = DIV_6;
      4'd7:    d = DIV_7;
      4'd8:    d = DIV_8;
      4'd9:    d = DIV_9;
      default: d = DIV_0;
    endcase
    return d;
  endfunction

  logic [CW-1:0] div_q, div_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          en_q, en_nxt;
  logic [CW-1:0] half_nxt, quarter_nxt, last_nxt;
  logic          clk_nxt, rise_nxt, fall_nxt, stable_nxt;

  // Next-state for divisor, phase counter and enable: a load restarts the
  // phase at 0 (and holds it there while the strobe stays high); otherwise
  // the counter free-runs and wraps from DIV-1 back to 0.
  always_comb begin
    en_nxt  = en_q;
    div_nxt = div_q;
    cnt_nxt = cnt_q;
    if (i_update_baud) begin
      en_nxt  = 1'b1;
      div_nxt = div_lookup(i_baud_select);
      cnt_nxt = '0;
    end else if (en_q) begin
      if (cnt_q == div_q - CW'(1)) cnt_nxt = '0;
      else                         cnt_nxt = cnt_q + CW'(1);
    end
  end

  // Output decode from the upcoming counter value, so the registered
  // outputs describe the phase that C holds after this edge.
  always_comb begin
    half_nxt    = div_nxt >> 1;
    quarter_nxt = div_nxt >> 2;
    last_nxt    = div_nxt - CW'(1);
    clk_nxt     = en_nxt && (cnt_nxt <= half_nxt);
    stable_nxt  = en_nxt && (cnt_nxt == quarter_nxt);
    fall_nxt    = en_nxt && (cnt_nxt == half_nxt);
    rise_nxt    = en_nxt && (cnt_nxt == last_nxt);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      en_q           <= 1'b0;
      div_q          <= DIV_0;
      cnt_q          <= '0;
      o_clk          <= 1'b0;
      o_rising_edge  <= 1'b0;
      o_falling_edge <= 1'b0;
      o_stable       <= 1'b0;
    end else begin
      en_q           <= en_nxt;
      div_q          <= div_nxt;
      cnt_q          <= cnt_nxt;
      o_clk          <= clk_nxt;
      o_rising_edge  <= rise_nxt;
      o_falling_edge <= fall_nxt;
      o_stable       <= stable_nxt;
    end
  end

endmodule

// File: tb/tb_baud_generator.sv
// Directed testbench for baud_generator at FPGA_CLK = 100 MHz.
// Inputs change 1 ns after a rising edge; outputs are observed at the same
// point, i.e. they show what was registered at the edge just passed.
module tb_baud_generator;

  logic       clk;
  logic       rst_n;
  logic [3:0] baud_select;
  logic       update_baud;
  logic       o_clk;
  logic       o_rising_edge;
  logic       o_falling_edge;
  logic       o_stable;

  int n_checks;
  int n_pass;

  // Hand-computed divisors for 100 MHz.
  int div_tab [10] = '{10416, 5208, 2604, 1736, 868, 434, 217, 108, 100, 66};

  baud_generator #(.FPGA_CLK(100_000_000)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_baud_select  (baud_select),
    .i_update_baud  (update_baud),
    .o_clk          (o_clk),
    .o_rising_edge  (o_rising_edge),
    .o_falling_edge (o_falling_edge),
    .o_stable       (o_stable)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle update pulse; returns just after the load edge (phase C=0).
  task automatic load(input logic [3:0] sel);
    baud_select = sel;
    update_baud = 1'b1;
    tick(1);
    update_baud = 1'b0;
  endtask

  task automatic test_reset();
    int nonzero;
    rst_n = 1'b0;
    tick(16);
    rst_n = 1'b1;
    tick(1);
    n_checks++; if (o_clk !== 1'b0) $display("FAIL reset_clk: got %b expected 0", o_clk); else n_pass++;
    n_checks++; if (o_rising_edge !== 1'b0) $display("FAIL reset_rise: got %b expected 0", o_rising_edge); else n_pass++;
    n_checks++; if (o_falling_edge !== 1'b0) $display("FAIL reset_fall: got %b expected 0", o_falling_edge); else n_pass++;
    n_checks++; if (o_stable !== 1'b0) $display("FAIL reset_stable: got %b expected 0", o_stable); else n_pass++;
    nonzero = 0;
    for (int i = 0; i < 40; i++) begin
      if ({o_clk, o_rising_edge, o_falling_edge, o_stable} !== 4'b0000) nonzero++;
      tick(1);
    end
    n_checks++; if (nonzero !== 0) $display("FAIL idle_after_reset: got %0d active cycles expected 0", nonzero); else n_pass++;
  endtask

  task automatic test_select0();
    load(4'd0);
    n_checks++; if (o_clk !== 1'b1) $display("FAIL load0_clk: got %b expected 1", o_clk); else n_pass++;
    n_checks++; if ({o_rising_edge, o_falling_edge, o_stable} !== 3'b000)
      $display("FAIL load0_strobes: got %b expected 000", {o_rising_edge, o_falling_edge, o_stable}); else n_pass++;
    tick(2603);
    n_checks++; if (o_stable !== 1'b0) $display("FAIL sel0_pre_stable: got %b expected 0", o_stable); else n_pass++;
    tick(1);
    n_checks++; if ({o_stable, o_clk} !== 2'b11) $display("FAIL sel0_stable: got stable,clk=%b expected 11", {o_stable, o_clk}); else n_pass++;
    tick(5208 - 2604);
    n_checks++; if ({o_falling_edge, o_clk, o_stable} !== 3'b110)
      $display("FAIL sel0_fall: got fall,clk,stable=%b expected 110", {o_falling_edge, o_clk, o_stable}); else n_pass++;
    tick(1);
    n_checks++; if ({o_clk, o_falling_edge} !== 2'b00) $display("FAIL sel0_clk_low: got clk,fall=%b expected 00", {o_clk, o_falling_edge}); else n_pass++;
  endtask

  task automatic test_sweep();
    int d, high_n, stab_n, fall_n, rise_n, stab_at, fall_at, rise_at, ovl;
    for (int s = 0; s < 10; s++) begin
      d = div_tab[s];
      load(4'(s));
      high_n = 0; stab_n = 0; fall_n = 0; rise_n = 0; ovl = 0;
      stab_at = -1; fall_at = -1; rise_at = -1;
      for (int k = 0; k < d; k++) begin
        if (o_clk) high_n++;
        if (o_stable) begin stab_n++; stab_at = k; end
        if (o_falling_edge) begin fall_n++; fall_at = k; end
        if (o_rising_edge) begin rise_n++; rise_at = k; end
        if (int'(o_stable) + int'(o_falling_edge) + int'(o_rising_edge) > 1) ovl++;
        if (o_falling_edge && !o_clk) ovl++;
        if (o_rising_edge && o_clk) ovl++;
        tick(1);
      end
      n_checks++; if (stab_n !== 1 || stab_at !== d / 4)
        $display("FAIL sweep%0d_stable: got %0d pulses at %0d expected 1 at %0d", s, stab_n, stab_at, d / 4); else n_pass++;
      n_checks++; if (fall_n !== 1 || fall_at !== d / 2)
        $display("FAIL sweep%0d_fall: got %0d pulses at %0d expected 1 at %0d", s, fall_n, fall_at, d / 2); else n_pass++;
      n_checks++; if (rise_n !== 1 || rise_at !== d - 1)
        $display("FAIL sweep%0d_rise: got %0d pulses at %0d expected 1 at %0d", s, rise_n, rise_at, d - 1); else n_pass++;
      n_checks++; if (high_n !== d / 2 + 1)
        $display("FAIL sweep%0d_high: got %0d expected %0d", s, high_n, d / 2 + 1); else n_pass++;
      n_checks++; if (ovl !== 0) $display("FAIL sweep%0d_overlap: got %0d expected 0", s, ovl); else n_pass++;
      // Period is exactly d: phase d is the next period's C=0.
      n_checks++; if ({o_clk, o_rising_edge, o_falling_edge, o_stable} !== 4'b1000)
        $display("FAIL sweep%0d_wrap: got %b expected 1000", s, {o_clk, o_rising_edge, o_falling_edge, o_stable}); else n_pass++;
    end
  endtask

  task automatic test_reselect();
    load(4'd4);
    tick(300);
    n_checks++; if (o_clk !== 1'b1) $display("FAIL resel_pre_clk: got %b expected 1", o_clk); else n_pass++;
    load(4'd9);
    n_checks++; if (o_clk !== 1'b1) $display("FAIL resel_load_clk: got %b expected 1", o_clk); else n_pass++;
    tick(16);
    n_checks++; if (o_stable !== 1'b1) $display("FAIL resel_stable: got %b expected 1", o_stable); else n_pass++;
    tick(16);
    n_checks++; if (o_falling_edge !== 1'b0) $display("FAIL resel_pre_fall: got %b expected 0", o_falling_edge); else n_pass++;
    tick(1);
    n_checks++; if (o_falling_edge !== 1'b1) $display("FAIL resel_fall: got %b expected 1", o_falling_edge); else n_pass++;
    tick(32);
    n_checks++; if (o_rising_edge !== 1'b1) $display("FAIL resel_rise: got %b expected 1", o_rising_edge); else n_pass++;
  endtask

  task automatic test_hold_update();
    int bad;
    baud_select = 4'd8;
    update_baud = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if ({o_clk, o_rising_edge, o_falling_edge, o_stable} !== 4'b1000) bad++;
    end
    update_baud = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL hold_update: got %0d bad cycles expected 0", bad); else n_pass++;
    tick(49);
    n_checks++; if (o_falling_edge !== 1'b0) $display("FAIL hold_pre_fall: got %b expected 0", o_falling_edge); else n_pass++;
    tick(1);
    n_checks++; if (o_falling_edge !== 1'b1) $display("FAIL hold_fall: got %b expected 1", o_falling_edge); else n_pass++;
  endtask

  task automatic test_select12();
    load(4'd12);
    tick(2604);
    n_checks++; if (o_stable !== 1'b1) $display("FAIL sel12_stable: got %b expected 1", o_stable); else n_pass++;
    tick(5208 - 2604);
    n_checks++; if (o_falling_edge !== 1'b1) $display("FAIL sel12_fall: got %b expected 1", o_falling_edge); else n_pass++;
    tick(10415 - 5208);
    n_checks++; if ({o_rising_edge, o_clk} !== 2'b10) $display("FAIL sel12_rise: got rise,clk=%b expected 10", {o_rising_edge, o_clk}); else n_pass++;
    tick(1);
    n_checks++; if ({o_clk, o_rising_edge} !== 2'b10) $display("FAIL sel12_wrap: got clk,rise=%b expected 10", {o_clk, o_rising_edge}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nonzero;
    load(4'd5);
    tick(108);
    n_checks++; if (o_stable !== 1'b1) $display("FAIL mid_pre_stable: got %b expected 1", o_stable); else n_pass++;
    rst_n = 1'b0;
    tick(1);
    n_checks++; if ({o_clk, o_rising_edge, o_falling_edge, o_stable} !== 4'b0000)
      $display("FAIL mid_reset: got %b expected 0000", {o_clk, o_rising_edge, o_falling_edge, o_stable}); else n_pass++;
    rst_n = 1'b1;
    nonzero = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if ({o_clk, o_rising_edge, o_falling_edge, o_stable} !== 4'b0000) nonzero++;
    end
    n_checks++; if (nonzero !== 0) $display("FAIL mid_idle: got %0d active cycles expected 0", nonzero); else n_pass++;
    load(4'd8);
    n_checks++; if (o_clk !== 1'b1) $display("FAIL mid_reload_clk: got %b expected 1", o_clk); else n_pass++;
    tick(25);
    n_checks++; if (o_stable !== 1'b1) $display("FAIL mid_reload_stable: got %b expected 1", o_stable); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    baud_select = 4'd0;
    update_baud = 1'b0;
    test_reset();
    test_select0();
    test_sweep();
    test_reselect();
    test_hold_update();
    test_select12();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
